// File: rtl/lbist_pattern_gen_if.sv
// LBIST pattern generator bus: run control, CUT pattern/response, signature.
// LBIST_GOLDEN_CMP_EN adds the GOLDEN input and PASS output.
interface lbist_pattern_gen_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [WIDTH-1:0] SEED;
  logic [7:0]       NUM_PAT;
  logic [WIDTH-1:0] RESP;
  logic [WIDTH-1:0] PAT;
  logic             PAT_VALID;
  logic [WIDTH-1:0] SIG_OUT;
  logic             BUSY;
  logic             DONE;
`ifdef LBIST_GOLDEN_CMP_EN
  logic [WIDTH-1:0] GOLDEN;
  logic             PASS;

  modport master (
    output START, SEED, NUM_PAT, RESP, GOLDEN,
    input  PAT, PAT_VALID, SIG_OUT, BUSY, DONE, PASS
  );

  modport slave (
    input  START, SEED, NUM_PAT, RESP, GOLDEN,
    output PAT, PAT_VALID, SIG_OUT, BUSY, DONE, PASS
  );
`else
  modport master (
    output START, SEED, NUM_PAT, RESP,
    input  PAT, PAT_VALID, SIG_OUT, BUSY, DONE
  );

  modport slave (
    input  START, SEED, NUM_PAT, RESP,
    output PAT, PAT_VALID, SIG_OUT, BUSY, DONE
  );
`endif
endinterface

// File: rtl/lbist_pattern_gen.sv
// LBIST pattern source (Galois LFSR) and response compactor (MISR).
// Optional golden compare under LBIST_GOLDEN_CMP_EN.
module lbist_pattern_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 'hB8,
  parameter logic [WIDTH-1:0] MISR_TAPS = 'hB8,
  parameter int               CUT_LAT   = 1
) (
  input logic CLK,
  input logic RST,
  lbist_pattern_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [8:0] LAT_M1 =
    9'((CUT_LAT == 0) ? 0 : CUT_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;
  logic [WIDTH-1:0] misr_nxt;
  logic [WIDTH-1:0] misr_fin;
  logic [WIDTH-1:0] sig_q;
  logic [8:0]       cnt;
  logic [7:0]       n_m1;
  logic             pat_valid;
  logic             resp_en;
  logic             last_pat;
  logic             drain_end;
  logic             enter_done;

  assign pat_valid  = (state == S_RUN);
  assign last_pat   = (cnt == {1'b0, n_m1});
  assign drain_end  = (cnt == LAT_M1);
  assign enter_done = (state_nxt == S_DONE)
                   && (state != S_DONE);

  assign misr_nxt = ((misr >> 1)
                  ^ (misr[0] ? MISR_TAPS : '0))
                  ^ bus.RESP;
  assign misr_fin = resp_en ? misr_nxt : misr;

  generate
    if (CUT_LAT == 0) begin : g_nolat
      assign resp_en = pat_valid;
    end else begin : g_lat
      logic [CUT_LAT-1:0] pv;
      // Delay PAT_VALID by the CUT latency to time response capture
      always_ff @(posedge CLK) begin
        if (RST || state == S_LOAD) begin
          pv <= '0;
        end else begin
          pv[0] <= pat_valid;
          for (int i = 1; i < CUT_LAT; i++)
            pv[i] <= pv[i-1];
        end
      end
      assign resp_en = pv[CUT_LAT-1];
    end
  endgenerate

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.START) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN: begin
        if (last_pat)
          state_nxt = (CUT_LAT == 0) ? S_DONE
                                     : S_DRAIN;
      end
      S_DRAIN: if (drain_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // LFSR, pattern/drain counter and signature capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr  <= 'd1;
      misr  <= '0;
      cnt   <= '0;
      n_m1  <= '0;
      sig_q <= '0;
    end else begin
      if (state == S_LOAD) misr <= '0;
      else if (resp_en)    misr <= misr_nxt;
      if (enter_done) sig_q <= misr_fin;
      unique case (state)
        S_LOAD: begin
          lfsr <= (bus.SEED == '0) ? 'd1 : bus.SEED;
          cnt  <= '0;
          n_m1 <= bus.NUM_PAT - 8'd1;
        end
        S_RUN: begin
          lfsr <= (lfsr >> 1)
                ^ (lfsr[0] ? LFSR_TAPS : '0);
          cnt  <= last_pat ? 9'd0 : cnt + 9'd1;
        end
        S_DRAIN: cnt <= cnt + 9'd1;
        default: ;
      endcase
    end
  end

`ifdef LBIST_GOLDEN_CMP_EN
  logic pass_q;
  // Compare final signature with the golden value
  always_ff @(posedge CLK) begin
    if (RST)             pass_q <= 1'b0;
    else if (enter_done) pass_q <= (misr_fin == bus.GOLDEN);
  end
  assign bus.PASS = pass_q;
`endif

  assign bus.PAT       = pat_valid ? lfsr : '0;
  assign bus.PAT_VALID = pat_valid;
  assign bus.SIG_OUT   = sig_q;
  assign bus.BUSY      = (state == S_LOAD)
                      || (state == S_RUN)
                      || (state == S_DRAIN);
  assign bus.DONE      = (state == S_DONE);

endmodule
